uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver for 8N1 serial input (optional parity).
- Synchronises the asynchronous line, validates the start bit and majority-votes three samples at each bit centre.
- Checks the stop bit and pushes good bytes into a small first-word-fall-through FIFO drained with a valid/ready handshake.
- It is the receiving end of the team's UART transmitter, and sits between the pad and the byte-stream consumer.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (clock freq / baud); must be >= 8.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
i_Clock  input  1  system clock, rising edge.
i_Rst  input  1  asynchronous, active-high reset.
i_RX_Serial  input  1  asynchronous serial line; idles high.
o_RX_Valid  output  1  FIFO not empty.
o_RX_Byte  output  8  FIFO head byte; valid when o_RX_Valid=1.
i_RX_Ready  input  1  consumer accepts the head when o_RX_Valid=1.
o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.
o_Overrun  output  1  sticky; a good byte arrived while the FIFO was full.
i_Clear_Err  input  1  clears o_Overrun (and o_Parity_Err); takes priority over a same-cycle set.
o_Busy  output  1  high in every state except IDLE.
o_Parity_Err  output  1  sticky parity error; port exists only when UART_RX_PARITY_EN is defined.

Behaviour:
Reset:
- Synchroniser flops = 1; state = IDLE; counters = 0; FIFO empty.
- o_RX_Valid = 0, o_RX_Byte = 0, o_Frame_Err = 0, o_Overrun = 0, o_Busy = 0, o_Parity_Err = 0.
- Reset asserted mid-frame aborts the frame and discards the FIFO contents.

Synchroniser and sampling:
- 2-flop synchroniser; rxs is its output. All decisions use rxs.
- Majority vote: 2-of-3 over rxs sampled at the three consecutive counts that end at the sample point.

State machine (counter cnt):
- IDLE: cnt=0, bit index=0. rxs==0 -> START.
- START: cnt counts up. At cnt==(CLKS_PER_BIT-1)/2, a single sample of rxs decides: 0 -> DATA with cnt=0; 1 -> IDLE (glitch rejected, nothing reported).
- DATA: sample point is cnt==CLKS_PER_BIT-1. The voted bit shifts in LSB first and cnt resets. After bit 7 -> STOP, or PARITY when the macro is defined.
- STOP: sample at cnt==CLKS_PER_BIT-1.
  - Voted 1 -> push the byte, go to IDLE.
  - Voted 0 -> pulse o_Frame_Err for exactly one cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then IDLE. A held-low break reports only one error.
- IDLE is re-entered at mid stop bit, so back-to-back frames with a one-bit stop are received without loss.

FIFO:
- First-word-fall-through. A byte pushed in cycle N appears on o_RX_Byte and o_RX_Valid in cycle N+1.
- Pop occurs when o_RX_Valid && i_RX_Ready; the next entry is presented the following cycle.
- Full and push with no pop in the same cycle: byte dropped, o_Overrun set, FIFO contents unchanged.
- Full and push with a pop in the same cycle: both happen and the occupancy count is unchanged; no overrun.
- Empty: i_RX_Ready is ignored; o_RX_Byte holds its last value.
- Pointers use log2(FIFO_DEPTH) bits and wrap naturally; the occupancy counter is log2(FIFO_DEPTH)+1 bits.

End-to-end latency: start falling edge to o_RX_Valid is about 9.5 bit times plus 3 cycles (2 synchroniser + 1 push).

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP, with parity sampled the same way as data bits. Even parity: the XOR of the 8 data bits plus the parity bit must be 0.
  - On mismatch, o_Parity_Err is set (sticky) and the byte is discarded. STOP is still checked; a framing error is also reported if the stop bit is low.
  - The frame is 11 bits.
- Undefined: no PARITY state, no o_Parity_Err port, 10-bit frame.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 8N1, i_RX_Ready=1 -> o_RX_Valid one cycle with o_RX_Byte=0xA5, about 79 cycles after the start edge; o_Frame_Err stays 0.
- Line low for 2 cycles, then high -> FSM returns to IDLE; o_RX_Valid, o_Frame_Err and o_Busy drop back with no byte pushed.
- Send 0x3C with the stop bit driven low for a 12-bit-time break -> exactly one o_Frame_Err pulse, no push, FSM stays in WAIT_HIGH until the line rises.
- i_RX_Ready=0, send 0x01..0x05 back-to-back (FIFO_DEPTH=4) -> o_Overrun=1; draining yields 0x01, 0x02, 0x03, 0x04, then o_RX_Valid=0. i_Clear_Err clears o_Overrun.
- Send 0x81 with a one-cycle high spike at bit-1 centre -> majority vote rejects it, received byte = 0x81. Assert i_Rst mid-byte of the next frame -> all outputs return to reset values; a subsequent 0x55 is received correctly.
- UART_RX_PARITY_EN: send 0x07 with a correct parity bit (1) -> byte delivered; send 0x07 with parity bit 0 -> o_Parity_Err=1, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (2-flop sync, 3-sample majority vote) feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky o_Parity_Err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_Valid,
  output logic [7:0] o_RX_Byte,
  input  logic       i_RX_Ready,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  input  logic       i_Clear_Err,
  output logic       o_Busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_Parity_Err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sync1, rxs;
  logic [1:0]    hist;
  logic          vote;
  logic          push_vld;
  logic [7:0]    push_dat;
  logic          frame_err;

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      hist  <= 2'b11;
    end else begin
      sync1 <= i_RX_Serial;
      rxs   <= sync1;
      hist  <= {hist[0], rxs};
    end
  end

  // hist holds rxs from the two counts before the sample point
  assign vote = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_set, par_err;
  assign par_set = (state == PARITY) && (cnt == LAST) && ((^shreg) ^ vote);
`endif

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      push_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {vote, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= STOP;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_set;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (vote) begin
`ifdef UART_RX_PARITY_EN
              push_vld <= !par_bad;
`else
              push_vld <= 1'b1;
`endif
              push_dat <= shreg;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Busy      = (state != IDLE);
  assign o_Frame_Err = frame_err;

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst)            par_err <= 1'b0;
    else if (i_Clear_Err) par_err <= 1'b0;
    else if (par_set)     par_err <= 1'b1;
  end
  assign o_Parity_Err = par_err;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [PW:0]   count, cnt_n;
  logic          pop, do_push, full;
  logic [7:0]    head;
  logic          overrun;

  always_comb begin
    full    = (count == FULL);
    pop     = (count != '0) && i_RX_Ready;
    do_push = push_vld && (!full || pop);
    rd_n    = pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_n   = count;
    if (do_push && !pop) cnt_n = count + 1'b1;
    else if (!do_push && pop) cnt_n = count - 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_n;
      count  <= cnt_n;
      // Head register keeps its last value once the FIFO drains
      if (cnt_n != '0)
        head <= (do_push && (wr_ptr == rd_n)) ? push_dat : mem[rd_n];
      if (i_Clear_Err)
        overrun <= 1'b0;
      else if (push_vld && full && !pop)
        overrun <= 1'b1;
    end
  end

  assign o_RX_Valid = (count != '0);
  assign o_RX_Byte  = head;
  assign o_Overrun  = overrun;

endmodule
